fpga_input_cond: RTL and testbench

FPGA_INPUT_COND -- requirements
Module: fpga_input_cond

---
 rtl/fpga_input_cond.sv | 76 +++++++
 tb/tb_fpga_input_cond.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fpga_input_cond.sv
// rtl/fpga_input_cond.sv - synchronize, debounce and edge-detect 2 buttons and 10 switches
module fpga_input_cond #(
    parameter int DB_CYCLES = 250000,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic       CLK_50,
    input  logic       RstQnnnH,
    input  logic [1:0] BUTTON,
    input  logic [9:0] SW,
    output logic [1:0] btn_db,
    output logic [1:0] btn_press,
    output logic [1:0] btn_release,
    output logic [9:0] sw_db,
    output logic [9:0] sw_rise,
    output logic [9:0] sw_fall
);

    // Channels 11:10 are the active-low buttons (idle high), 9:0 the switches (idle low).
    localparam int          NCH   = 12;
    localparam logic [11:0] RST_V = {2'b11, 10'h000};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [NCH-1:0]            sync1_q, sync2_q;
    logic [NCH-1:0]            db_q, db_d;
    logic [NCH-1:0]            rise_q, rise_d;
    logic [NCH-1:0]            fall_q, fall_d;
    logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Per-channel debounce: count consecutive mismatching samples, accept on the last one.
    always_comb begin
        db_d   = db_q;
        cnt_d  = cnt_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                db_d[i]   = sync2_q[i];
                cnt_d[i]  = '0;
                rise_d[i] = sync2_q[i];
                fall_d[i] = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Synchronizer chain, debounced levels, counters and registered edge pulses.
    always_ff @(posedge CLK_50) begin
        if (RstQnnnH) begin
            sync1_q <= RST_V;
            sync2_q <= RST_V;
            db_q    <= RST_V;
            cnt_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            sync1_q <= {BUTTON, SW};
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Buttons are active-low, so a press is the falling edge of the debounced level.
    assign btn_db      = db_q[11:10];
    assign btn_press   = fall_q[11:10];
    assign btn_release = rise_q[11:10];
    assign sw_db       = db_q[9:0];
    assign sw_rise     = rise_q[9:0];
    assign sw_fall     = fall_q[9:0];

endmodule

// File: tb/tb_fpga_input_cond.sv
// tb/tb_fpga_input_cond.sv - scoreboard bench for fpga_input_cond against a sample-window model
module tb_fpga_input_cond;

    localparam int          DB    = 4;
    localparam logic [11:0] RST_V = {2'b11, 10'h000};

    logic       CLK_50 = 1'b0;
    logic       RstQnnnH = 1'b1;
    logic [1:0] BUTTON = 2'b11;
    logic [9:0] SW = 10'h000;
    logic [1:0] btn_db, btn_press, btn_release;
    logic [9:0] sw_db, sw_rise, sw_fall;

    fpga_input_cond #(.DB_CYCLES(DB)) dut (
        .CLK_50     (CLK_50),
        .RstQnnnH   (RstQnnnH),
        .BUTTON     (BUTTON),
        .SW         (SW),
        .btn_db     (btn_db),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .sw_db      (sw_db),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall)
    );

    always #5 CLK_50 = ~CLK_50;

    typedef struct {
        int          cyc;
        logic [23:0] pulse;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          armed = 0;
    logic [11:0] dm = RST_V;

    // Reference model: a new level is accepted once the last DB synchronized samples
    // all disagree with the current level; samples pass through two capture stages.
    initial begin : model
        logic [11:0] s1m, s2m, acc, nd, rise, fall;
        logic [11:0] shist[$];
        exp_t        e;
        bit          all;
        s1m = RST_V;
        s2m = RST_V;
        forever begin
            @(posedge CLK_50);
            cyc++;
            if (RstQnnnH) begin
                s1m = RST_V;
                s2m = RST_V;
                dm  = RST_V;
                shist.delete();
                for (int j = 0; j < DB; j++) shist.push_back(RST_V);
                armed = 1;
            end else if (armed) begin
                acc = '0;
                for (int b = 0; b < 12; b++) begin
                    all = 1;
                    foreach (shist[j]) if (shist[j][b] == dm[b]) all = 0;
                    acc[b] = all;
                end
                nd   = dm ^ acc;
                rise = acc & nd;
                fall = acc & ~nd;
                if (acc != 0) begin
                    e.cyc   = cyc;
                    e.pulse = {fall[11:10], rise[11:10], rise[9:0], fall[9:0]};
                    expq.push_back(e);
                end
                dm  = nd;
                s2m = s1m;
                s1m = {BUTTON, SW};
                shist.push_back(s2m);
                void'(shist.pop_front());
            end
        end
    end

    // Monitor: checks levels every cycle and pops the scoreboard whenever a pulse appears.
    initial begin : monitor
        logic [23:0] act;
        exp_t        e;
        forever begin
            @(negedge CLK_50);
            if (armed) begin
                checks++;
                if ({btn_db, sw_db} !== dm) begin
                    failures++;
                    $display("FAIL level cyc=%0d actual=%h required=%h", cyc, {btn_db, sw_db}, dm);
                end
                while (expq.size() > 0 && expq[0].cyc < cyc) begin
                    e = expq.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL missed_pulse cyc=%0d actual=none required=%h", e.cyc, e.pulse);
                end
                act = {btn_press, btn_release, sw_rise, sw_fall};
                if (act !== 24'h0) begin
                    checks++;
                    if (expq.size() == 0) begin
                        failures++;
                        $display("FAIL extra_pulse cyc=%0d actual=%h required=none", cyc, act);
                    end else begin
                        e = expq.pop_front();
                        if (e.cyc != cyc || e.pulse !== act) begin
                            failures++;
                            $display("FAIL pulse cyc=%0d actual=%h required=%h@%0d", cyc, act, e.pulse, e.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge CLK_50);
        #2;
    endtask

    task automatic expect_lvl(input string name, input logic [11:0] act, input logic [11:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    initial begin : stim
        hold(3);
        expect_lvl("reset_state", {btn_db, sw_db}, RST_V);
        RstQnnnH = 1'b0;
        hold(5);

        // clean press, then release
        BUTTON[0] = 1'b0; hold(20);
        expect_lvl("press_level", {10'h0, btn_db}, 12'h002);
        BUTTON[0] = 1'b1; hold(20);
        expect_lvl("release_level", {10'h0, btn_db}, 12'h003);

        // short glitch on BUTTON[1]
        BUTTON[1] = 1'b0; hold(3);
        BUTTON[1] = 1'b1; hold(20);
        expect_lvl("glitch_level", {10'h0, btn_db}, 12'h003);

        // bounce on SW[3]
        for (int k = 0; k < 4; k++) begin
            SW[3] = ~k[0]; hold(3);
        end
        SW[3] = 1'b1; hold(20);
        expect_lvl("bounce_level", {2'b0, sw_db}, 12'h008);

        // simultaneous rise of all switches
        SW = 10'h000; hold(20);
        SW = 10'h3FF; hold(20);
        expect_lvl("simul_level", {2'b0, sw_db}, 12'h3FF);

        // reset mid-count
        SW = 10'h000; hold(20);
        SW[0] = 1'b1; hold(3);
        RstQnnnH = 1'b1; hold(1);
        expect_lvl("reset_mid", {2'b0, sw_db}, 12'h000);
        RstQnnnH = 1'b0; hold(20);
        expect_lvl("after_reset", {2'b0, sw_db}, 12'h001);

        // held button across reset is accepted as a press
        BUTTON = 2'b10;
        RstQnnnH = 1'b1; hold(2);
        RstQnnnH = 1'b0; hold(20);
        expect_lvl("btn_after_reset", {10'h0, btn_db}, 12'h002);

        // random bouncing on all channels with occasional resets
        for (int seg = 0; seg < 400; seg++) begin
            logic [11:0] v, m;
            v = {BUTTON, SW};
            m = 12'($urandom) & 12'($urandom);
            {BUTTON, SW} = v ^ m;
            RstQnnnH = ($urandom_range(0, 59) == 0);
            hold($urandom_range(1, 9));
            RstQnnnH = 1'b0;
        end
        hold(20);

        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL pending_pulses actual=%0d required=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
